lcd_bus_rx: RTL and testbench
=============================

Name: lcd_bus_rx

Overview:
- Receiving end of the 8-bit 8080-style LCD write bus (D[7:0], RS, WR_n, CS_n) that the LCD write PHY drives.
- Oversamples the asynchronous bus pins with the system clock and detects WR_n rising edges while CS_n is low.
- Queues each captured {RS, D} byte into a small FIFO and presents it as a valid/ready stream.
- Used for bus sniffing, display emulation and loopback verification of the LCD write path.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per bus pin (minimum 2).
- FIFO_LOG2, 2, log2 of FIFO depth (default 4 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- lcd_d  in  8  bus data, asynchronous.
- lcd_rs  in  1  0 = command, 1 = data; asynchronous.
- lcd_wr_n  in  1  write strobe; data latched on rising edge; asynchronous.
- lcd_cs_n  in  1  chip select, active-low; asynchronous.
- rx_ena  in  1  capture enable.
- out_data  out  8  captured byte.
- out_rs  out  1  captured RS.
- out_first  out  1  first data byte after a command.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- cmd_last  out  8  last command byte received.
- data_cnt  out  16  data bytes since last command.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset values:
  - Synchroniser stages: wr_n = 1, cs_n = 1, d = 0, rs = 0.
  - Outputs: out_valid = 0, out_data = 0, out_rs = 0, out_first = 0, cmd_last = 0x00, data_cnt = 0, ovf = 0. FIFO empty.
- Sync: every pin passes through SYNC_STAGES flops, then one further "prev" register.
- Capture event: wr_sync = 1 and wr_prev = 0 and cs_prev = 0. Captured value is {rs_prev, d_prev}, i.e. the sample taken one cycle before the rising edge was seen.
- Bus timing contract:
  - WR_n low ≥ 2 clk.
  - WR_n high ≥ 2 clk.
  - D/RS stable ≥ 2 clk before and ≥ 1 clk after the WR_n rise.
  - Faster buses are out of spec; behaviour is then undefined but must not lock up.
- Edges while CS_n is high are ignored.
- If rx_ena = 0 the capture event is ignored. FIFO contents are retained and still drain.
- Latency: the pin edge appears as out_valid SYNC_STAGES + 2 cycles later, provided the FIFO was empty.
- FIFO:
  - Depth 2^FIFO_LOG2; entry = {first, rs, d}; first-word-fall-through.
  - Push on a capture event when not full, or when full with a pop in the same cycle.
  - When full without a pop: drop the byte and set ovf. A dropped byte does not change cmd_last or data_cnt.
- Output stream:
  - out_valid = FIFO non-empty; pop on out_valid & out_ready.
  - out_data / out_rs / out_first are held stable while out_valid & ~out_ready.
- ovf: set on drop, cleared by ovf_clr. A simultaneous drop and clear leaves ovf = 1.
- CS_n deassert (cs_sync = 1, cs_prev = 0): resets the command tracker (cmd_last kept, data_cnt = 0, next data not marked first). Does not touch the FIFO.
- Reset mid-operation: FIFO is flushed; a partially observed WR pulse is discarded because the synchronisers restart at wr_n = 1.

Optional Feature:
- Macro: LCD_BUS_RX_CMDTRACK_EN.
- Defined:
  - On an accepted command capture: cmd_last = d, data_cnt = 0, arm first flag.
  - On an accepted data capture: data_cnt increments, saturating at 0xFFFF. out_first = 1 on the first data entry after a command; the flag is then disarmed.
- Undefined: cmd_last = 0x00, data_cnt = 0, out_first = 0 constantly, and no tracker logic is instantiated.

Decomposition:
- Shared lcd defines include:
  - LCD command constants: CMD_NOP 0x00, CMD_CASET 0x2A, CMD_PASET 0x2B, CMD_RAMWR 0x2C.
  - RS encoding constants: RS_CMD = 0, RS_DATA = 1.
  - FIFO entry width constant: 10.
- Sub-module: lcd_rx_fifo, a generic synchronous FWFT FIFO with push/pop/full/empty, parameterised width and depth.

Test Plan:
- Reset then single write, cs_n = 0, rs = 0, d = 0x2C, WR low 3 clk → one entry out_rs = 0, out_data = 0x2C, out_valid at SYNC_STAGES + 2 after the rise; cmd_last = 0x2C.
- Command 0x2C then data 0x12, 0x34, 0x56 → out_first = 1 only on 0x12; data_cnt = 3; second command 0x2A → data_cnt = 0.
- out_ready = 0, 6 writes, depth 4 → 4 entries kept (first four, in order), ovf = 1; ovf_clr while a 7th write is dropped → ovf stays 1; next clean ovf_clr → 0.
- WR pulses with cs_n = 1, or with rx_ena = 0 → no entries, counters unchanged.
- Full FIFO with out_ready = 1 and a write landing on a pop cycle → byte accepted, ovf = 0, order preserved.
- Assert rst during a WR low phase, release, then WR rises → no entry; the next full write is captured normally.

Source files
------------

// File: rtl/lcd_bus_rx_pkg.sv
// Shared LCD bus definitions: command codes, RS encoding, FIFO entry and pin bundle types.
package lcd_bus_rx_pkg;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int unsigned ENTRY_W = 10;

  typedef struct packed {
    logic       first;
    logic       rs;
    logic [7:0] d;
  } rx_entry_t;

  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       rs;
    logic [7:0] d;
  } pin_t;

  // Idle bus as seen right after reset: strobe and select deasserted.
  localparam pin_t PIN_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, rs: 1'b0, d: 8'h00};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head entry is visible on rdata while not empty.
module lcd_rx_fifo #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q;
  logic [DEPTH_LOG2:0] rd_ptr_q;
  logic                do_push;
  logic                do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_rx.sv
// 8080-style LCD write-bus receiver: synchronises pins, captures on WR_n rise, queues {first, rs, d}.
// Optional command/data tracker is built only when LCD_BUS_RX_CMDTRACK_EN is defined.
module lcd_bus_rx
  import lcd_bus_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  lcd_d,
  input  logic        lcd_rs,
  input  logic        lcd_wr_n,
  input  logic        lcd_cs_n,
  input  logic        rx_ena,
  output logic [7:0]  out_data,
  output logic        out_rs,
  output logic        out_first,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  cmd_last,
  output logic [15:0] data_cnt,
  output logic        ovf,
  input  logic        ovf_clr
);

  pin_t pin_raw;
  pin_t sync_q [SYNC_STAGES];
  pin_t pin_sync;
  pin_t prev_q;

  logic       capture;
  logic       cap_vld_q;
  logic       cap_rs_q;
  logic [7:0] cap_d_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       accept;
  logic       drop;
  logic       first_flag;
  logic       ovf_q;
  rx_entry_t  wr_entry;
  rx_entry_t  rd_entry;

  assign pin_raw = '{cs_n: lcd_cs_n, wr_n: lcd_wr_n, rs: lcd_rs, d: lcd_d};

  // SYNC_STAGES must be at least 2 for metastability settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= PIN_IDLE;
      end
      prev_q <= PIN_IDLE;
    end else begin
      sync_q[0] <= pin_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= pin_sync;
    end
  end

  assign pin_sync = sync_q[SYNC_STAGES-1];

  // Data is taken from the sample before the edge was seen, while it is still known stable.
  assign capture = pin_sync.wr_n & ~prev_q.wr_n & ~prev_q.cs_n & rx_ena;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_q <= 1'b0;
      cap_rs_q  <= 1'b0;
      cap_d_q   <= 8'h00;
    end else begin
      cap_vld_q <= capture;
      if (capture) begin
        cap_rs_q <= prev_q.rs;
        cap_d_q  <= prev_q.d;
      end
    end
  end

  assign pop    = out_valid & out_ready;
  assign accept = cap_vld_q & (~fifo_full | pop);
  assign drop   = cap_vld_q & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;

`ifdef LCD_BUS_RX_CMDTRACK_EN
  logic        cs_rise;
  logic [7:0]  cmd_last_q;
  logic [15:0] data_cnt_q;
  logic        armed_q;

  assign cs_rise    = pin_sync.cs_n & ~prev_q.cs_n;
  assign first_flag = (cap_rs_q == RS_DATA) & armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_last_q <= CMD_NOP;
      data_cnt_q <= 16'h0000;
      armed_q    <= 1'b0;
    end else if (accept) begin
      if (cap_rs_q == RS_CMD) begin
        cmd_last_q <= cap_d_q;
        data_cnt_q <= 16'h0000;
        armed_q    <= 1'b1;
      end else begin
        data_cnt_q <= sat_inc16(data_cnt_q);
        armed_q    <= 1'b0;
      end
    end else if (cs_rise) begin
      data_cnt_q <= 16'h0000;
      armed_q    <= 1'b0;
    end
  end

  assign cmd_last = cmd_last_q;
  assign data_cnt = data_cnt_q;
`else
  assign first_flag = 1'b0;
  assign cmd_last   = CMD_NOP;
  assign data_cnt   = 16'h0000;
`endif

  assign wr_entry = '{first: first_flag, rs: cap_rs_q, d: cap_d_q};

  lcd_rx_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = rd_entry.d;
  assign out_rs    = rd_entry.rs;
  assign out_first = rd_entry.first;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Scoreboard bench for lcd_bus_rx: expected entries queued at stimulus time, checked on pop.
module tb_lcd_bus_rx;
  import lcd_bus_rx_pkg::*;

  localparam int SYNC_STAGES = 2;
`ifdef LCD_BUS_RX_CMDTRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lcd_d;
  logic        lcd_rs;
  logic        lcd_wr_n;
  logic        lcd_cs_n;
  logic        rx_ena;
  logic [7:0]  out_data;
  logic        out_rs;
  logic        out_first;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  cmd_last;
  logic [15:0] data_cnt;
  logic        ovf;
  logic        ovf_clr;

  int          nvec = 0;
  int          nerr = 0;
  rx_entry_t   sb[$];

  // Reference tracker state.
  bit          armed = 1'b0;
  logic [7:0]  cmd_m = 8'h00;
  logic [15:0] cnt_m = 16'h0000;

  lcd_bus_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .FIFO_LOG2   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_d     (lcd_d),
    .lcd_rs    (lcd_rs),
    .lcd_wr_n  (lcd_wr_n),
    .lcd_cs_n  (lcd_cs_n),
    .rx_ena    (rx_ena),
    .out_data  (out_data),
    .out_rs    (out_rs),
    .out_first (out_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cmd_last  (cmd_last),
    .data_cnt  (data_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_trk(input string tag);
    check({tag, "_cmd_last"}, 32'(cmd_last), TRK ? 32'(cmd_m) : 32'h0);
    check({tag, "_data_cnt"}, 32'(data_cnt), TRK ? 32'(cnt_m) : 32'h0);
  endtask

  task automatic model_accept(input logic rs, input logic [7:0] d);
    rx_entry_t e;
    e.rs    = rs;
    e.d     = d;
    e.first = 1'b0;
    if (rs == RS_CMD) begin
      cmd_m = d;
      cnt_m = 16'h0000;
      armed = 1'b1;
    end else begin
      e.first = armed;
      armed   = 1'b0;
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end
    if (!TRK) e.first = 1'b0;
    sb.push_back(e);
  endtask

  // WR low 3 clk, D held 2 clk before and 5 clk after the rise. Pulses land on the push cycle.
  task automatic bus_write(input logic rs, input logic [7:0] d, input bit acc,
                           input bit rdy_pulse = 1'b0, input bit clr_pulse = 1'b0,
                           input bit measure = 1'b0);
    int lat;
    if (acc) model_accept(rs, d);
    lcd_rs = rs;
    lcd_d  = d;
    tick();
    tick();
    lcd_wr_n = 1'b0;
    repeat (3) tick();
    lcd_wr_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (measure && lat == 0 && out_valid) lat = c;
      if (rdy_pulse) out_ready = (c == 3);
      if (clr_pulse) ovf_clr = (c == 3);
    end
    if (measure) check("latency", 32'(lat), 32'(SYNC_STAGES + 2));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (sb.size() != 0 || out_valid); i++) tick();
    check({tag, "_drain"}, 32'(sb.size() != 0 || out_valid), 32'h0);
  endtask

  // Pops and compares against the scoreboard; also checks head stability while stalled.
  logic       held_v = 1'b0;
  logic [9:0] held;
  rx_entry_t  mon_e;
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("hold", 32'({out_first, out_rs, out_data}), 32'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_extra_entry", 32'({out_rs, out_data}), 32'h400);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.d));
          check("out_rs", 32'(out_rs), 32'(mon_e.rs));
          check("out_first", 32'(out_first), 32'(mon_e.first));
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_first, out_rs, out_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    lcd_d     = 8'h00;
    lcd_rs    = 1'b0;
    lcd_wr_n  = 1'b1;
    lcd_cs_n  = 1'b1;
    rx_ena    = 1'b1;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) tick();

    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_rs", 32'(out_rs), 32'h0);
    check("rst_first", 32'(out_first), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check_trk("rst");

    rst      = 1'b0;
    lcd_cs_n = 1'b0;
    repeat (3) tick();

    // Single command, latency from WR rise to out_valid.
    bus_write(RS_CMD, CMD_RAMWR, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'h2C);
    check("t1_rs", 32'(out_rs), 32'h0);
    check_trk("t1");
    out_ready = 1'b1;
    drain("t1");

    // Data after command: first flag and counter.
    bus_write(RS_DATA, 8'h12, 1'b1);
    bus_write(RS_DATA, 8'h34, 1'b1);
    bus_write(RS_DATA, 8'h56, 1'b1);
    drain("t2");
    check_trk("t2_cnt3");
    bus_write(RS_CMD, CMD_CASET, 1'b1);
    drain("t2b");
    check_trk("t2_cmd2a");

    // Overflow with stalled sink, then drop coinciding with clear.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) bus_write(RS_DATA, 8'hA0 + 8'(i), i < 4);
    check("t3_ovf_set", 32'(ovf), 32'h1);
    check("t3_valid", 32'(out_valid), 32'h1);
    check_trk("t3_cnt4");
    bus_write(RS_DATA, 8'hA6, 1'b0, 1'b0, 1'b1);
    check("t3_ovf_sticky", 32'(ovf), 32'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    check("t3_ovf_clr", 32'(ovf), 32'h0);
    out_ready = 1'b1;
    drain("t3");

    // Capture disabled.
    rx_ena = 1'b0;
    bus_write(RS_CMD, CMD_PASET, 1'b0);
    bus_write(RS_DATA, 8'h5A, 1'b0);
    check("t4_ena_valid", 32'(out_valid), 32'h0);
    check_trk("t4_ena");
    rx_ena = 1'b1;

    // Chip select high: deassert clears the tracker count, strobes ignored.
    lcd_cs_n = 1'b1;
    repeat (4) tick();
    cnt_m = 16'h0000;
    armed = 1'b0;
    bus_write(RS_DATA, 8'h55, 1'b0);
    bus_write(RS_CMD, CMD_NOP, 1'b0);
    check("t4_cs_valid", 32'(out_valid), 32'h0);
    check_trk("t4_cs");
    lcd_cs_n = 1'b0;
    repeat (2) tick();

    // Full FIFO, write lands on a pop cycle.
    out_ready = 1'b0;
    bus_write(RS_CMD, CMD_PASET, 1'b1);
    bus_write(RS_DATA, 8'hB1, 1'b1);
    bus_write(RS_DATA, 8'hB2, 1'b1);
    bus_write(RS_DATA, 8'hB3, 1'b1);
    bus_write(RS_DATA, 8'hB4, 1'b1, 1'b1, 1'b0);
    check("t5_ovf", 32'(ovf), 32'h0);
    check("t5_valid", 32'(out_valid), 32'h1);
    check_trk("t5");
    out_ready = 1'b1;
    drain("t5");

    // Reset during WR low; WR rises with the reset release and must not capture.
    lcd_rs = RS_DATA;
    lcd_d  = 8'h99;
    tick();
    tick();
    lcd_wr_n = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    armed = 1'b0;
    cmd_m = 8'h00;
    cnt_m = 16'h0000;
    tick();
    tick();
    rst      = 1'b0;
    lcd_wr_n = 1'b1;
    repeat (10) tick();
    check("t6_no_entry", 32'(out_valid), 32'h0);
    check("t6_ovf", 32'(ovf), 32'h0);
    check_trk("t6");
    bus_write(RS_DATA, 8'h77, 1'b1);
    check_trk("t6_after");
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
